// File: rtl/dsc_stream_ctrl.sv
// dsc_stream_ctrl: sequences one stochastic-computing job (operand latch, SNG clear/run, ones count, result handshake)
module dsc_stream_ctrl #(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH*NUM_INPUTS-1:0]   in_data,
    output logic [WIDTH*NUM_INPUTS-1:0]   bin_out,
    output logic                          sng_rst,
    output logic                          sng_en,
    input  logic                          sn_in,
    input  logic                          ctr_overflow,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH:0]                out_data,
    output logic                          err
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    state_t                        state_q;
    logic [WIDTH*NUM_INPUTS-1:0]   bin_q;
    logic [WIDTH:0]                acc_q, acc_d, data_q;
    logic [WIDTH-1:0]              cyc_q;
    logic                          err_q, last;
    assign last      = cyc_q == '1;
    assign acc_d     = acc_q + (WIDTH+1)'(sn_in);
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign sng_rst   = rst | (state_q == CLEAR);
    assign sng_en    = state_q == RUN;
    assign out_valid = state_q == DONE;
    assign bin_out   = bin_q;
    assign out_data  = data_q;
    assign err       = err_q;
    // job FSM: accept, clear SNG, count 2**WIDTH stream bits, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    bin_q   <= in_data;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    acc_q   <= '0;
                    cyc_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q <= acc_d;
                    cyc_q <= cyc_q + 1'b1;
                    if (ctr_overflow != last) err_q <= 1'b1;
                    if (last) begin
                        data_q  <= acc_d;
                        state_q <= DONE;
                    end
                end
                default: if (out_ready) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsc_stream_ctrl.sv
// tb_dsc_stream_ctrl: directed checks of dsc_stream_ctrl with a counter-comparator SNG model
module tb_dsc_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic [3:0] bin_out;
    logic       sng_rst, sng_en, sn_in, ctr_overflow, out_valid, err;
    logic       out_ready = 1'b0;
    logic [4:0] out_data;
    logic [3:0] ctr = '0;
    logic       force_one = 1'b0;
    logic       inj = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         e = 0;
    int         acc_edges[$];
    int         res_q[$];

    dsc_stream_ctrl #(.WIDTH(4), .NUM_INPUTS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bin_out(bin_out), .sng_rst(sng_rst), .sng_en(sng_en), .sn_in(sn_in),
        .ctr_overflow(ctr_overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err(err)
    );

    always #5 clk = ~clk;

    // SNG counter and comparator stream source
    always @(posedge clk) begin
        if (sng_rst) ctr <= '0;
        else if (sng_en) ctr <= ctr + 4'd1;
    end
    assign sn_in        = force_one | (bin_out > ctr);
    assign ctr_overflow = sng_en & ((ctr == 4'hF) | (inj & (ctr == 4'd5)));

    // handshake logger
    always @(posedge clk) begin
        e <= e + 1;
        if (in_valid && in_ready) acc_edges.push_back(e);
        if (out_valid && out_ready) res_q.push_back(int'(out_data));
    end

    task automatic send(input logic [3:0] v);
        int k;
        in_data = v;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 50) begin
            failures++;
            $display("FAIL accept_timeout v=%0d in_ready=%b required=1", v, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] v, input int exp);
        int n;
        send(v);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 18) begin
            failures++;
            $display("FAIL latency v=%0d got=%0d required=18", v, n);
        end
        checks++;
        if (out_data !== 5'(exp)) begin
            failures++;
            $display("FAIL data v=%0d got=%0d required=%0d", v, out_data, exp);
        end
        checks++;
        if (sng_en !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_outputs v=%0d sng_en=%b in_ready=%b required=0,0", v, sng_en, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL retire v=%0d out_valid=%b in_ready=%b required=0,1", v, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || sng_rst !== 1'b1 || sng_en !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl in_ready=%b sng_rst=%b sng_en=%b out_valid=%b required=0,1,0,0",
                     in_ready, sng_rst, sng_en, out_valid);
        end
        checks++;
        if (err !== 1'b0 || out_data !== 5'd0 || bin_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_regs err=%b out_data=%0d bin_out=%0d required=0,0,0", err, out_data, bin_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sng_rst !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b sng_rst=%b required=1,0", in_ready, sng_rst);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_job(4'd10, 10);
        checks++;
        if (err !== 1'b0 || bin_out !== 4'd10) begin
            failures++;
            $display("FAIL basic err=%b bin_out=%0d required=0,10", err, bin_out);
        end
    endtask

    task automatic test_values();
        run_job(4'd0, 0);
        run_job(4'd15, 15);
        force_one = 1'b1;
        run_job(4'd5, 16);
        force_one = 1'b0;
    endtask

    task automatic test_hold();
        int n;
        send(4'd9);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 5'd9 || in_ready !== 1'b0 || sng_en !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d out_valid=%b out_data=%0d in_ready=%b sng_en=%b required=1,9,0,0",
                         i, out_valid, out_data, in_ready, sng_en);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_retire out_valid=%b in_ready=%b required=0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3] = '{4'd3, 4'd7, 4'd12};
        int k, n0;
        acc_edges.delete();
        res_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            n0 = acc_edges.size();
            k = 0;
            while (acc_edges.size() == n0 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        in_valid = 1'b0;
        k = 0;
        while (res_q.size() < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        checks++;
        if (acc_edges.size() !== 3 || res_q.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d results=%0d required=3,3", acc_edges.size(), res_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_q[i] !== int'(vals[i])) begin
                    failures++;
                    $display("FAIL b2b_result_%0d got=%0d required=%0d", i, res_q[i], vals[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_edges[i] - acc_edges[i-1] !== 19) begin
                    failures++;
                    $display("FAIL b2b_spacing_%0d got=%0d required=19", i, acc_edges[i] - acc_edges[i-1]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int k;
        inj = 1'b1;
        in_data = 4'd6;
        in_valid = 1'b1;
        k = 0;
        while (!(sng_en === 1'b1 && ctr == 4'd5) && k < 50) begin
            @(negedge clk);
            k++;
            if (in_ready !== 1'b1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (k >= 50 || err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_before k=%0d err=%b required=<50,0", k, err);
        end
        @(negedge clk);
        inj = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set err=%b required=1", err);
        end
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_data !== 5'd6) begin
            failures++;
            $display("FAIL ovf_job_data got=%0d required=6", out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_job(4'd2, 2);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky err=%b required=1", err);
        end
        test_reset();
    endtask

    task automatic test_reset_midjob();
        int k, seen;
        in_data = 4'd10;
        in_valid = 1'b1;
        k = 0;
        while (!(sng_en === 1'b1 && ctr == 4'd8) && k < 50) begin
            @(negedge clk);
            k++;
            if (in_ready !== 1'b1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (k >= 50 || sng_en !== 1'b0 || out_valid !== 1'b0 || sng_rst !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst k=%0d sng_en=%b out_valid=%b sng_rst=%b in_ready=%b required=<50,0,0,1,0",
                     k, sng_en, out_valid, sng_rst, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || bin_out !== 4'd0) begin
            failures++;
            $display("FAIL midrst_release in_ready=%b bin_out=%0d required=1,0", in_ready, bin_out);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_result out_valid_cycles=%0d required=0", seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_values();
        test_hold();
        test_back_to_back();
        test_overflow();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
